// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state, coin and select encodings for the vending controller
// Ports: none (package). Provides state_t, coin/select codes and coin_value().
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

    localparam logic [1:0] SEL_A = 2'b01;
    localparam logic [1:0] SEL_B = 2'b10;

    // Half-unit value of a coin code; the invalid code is worth nothing.
    function automatic logic [1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_HALF: return 2'd1;
            COIN_ONE:  return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vending_ctrl_credit_acc.sv
// rtl/vending_ctrl_credit_acc.sv - credit register with saturating add and subtract
// Ports: clk, rstn; add_en/add_amt request an add, add_fits reports whether it
// stays within MAX_CREDIT; sub_en/sub_amt request a subtract; credit is the register.
module vend_credit_acc #(
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                add_en,
    input  logic [1:0]          add_amt,
    input  logic                sub_en,
    input  logic [CREDIT_W-1:0] sub_amt,
    output logic                add_fits,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

    // One extra bit so the ceiling test sees the true sum before truncation.
    logic [CREDIT_W:0] sum;

    assign sum      = {1'b0, credit} + {{(CREDIT_W-1){1'b0}}, add_amt};
    assign add_fits = (sum <= MAX_EXT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit <= '0;
        end else if (sub_en) begin
            credit <= credit - sub_amt;
        end else if (add_en && add_fits) begin
            credit <= sum[CREDIT_W-1:0];
        end
    end

endmodule

// File: rtl/vending_ctrl.sv
// rtl/vending_ctrl.sv - coin credit, product arbitration, dispense and change sequencing
// Ports: clk, rstn; coin/sel/cancel from the front end; vend_ack/chg_ack from the
// dispensers; sell/sell_id and chg_req/chg_coin requests; coin_rej/no_credit pulses;
// credit in half-units; busy while vending or paying change.
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 4,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          coin,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                chg_ack,
    output logic                sell,
    output logic                sell_id,
    output logic                chg_req,
    output logic                chg_coin,
    output logic                coin_rej,
    output logic                no_credit,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE_A_W = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PRICE_B_W = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W-1:0] ONE_W     = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TWO_W     = CREDIT_W'(2);

    state_t              state;
    logic                coin_valid;
    logic                sel_valid;
    logic [CREDIT_W-1:0] sel_price;
    logic                can_buy;
    logic                add_en;
    logic                add_fits;
    logic                sub_en;
    logic [CREDIT_W-1:0] sub_amt;
    logic [CREDIT_W-1:0] remainder;

    assign coin_valid = (coin == COIN_HALF) || (coin == COIN_ONE);
    assign sel_valid  = (sel == SEL_A) || (sel == SEL_B);
    assign sel_price  = (sel == SEL_B) ? PRICE_B_W : PRICE_A_W;
    // Affordability uses the credit before any same-cycle coin.
    assign can_buy    = sel_valid && (credit >= sel_price);

    assign add_en  = ((state == IDLE) || (state == ACCUM)) && !cancel && !can_buy && coin_valid;
    assign sub_en  = ((state == VEND) && vend_ack) || ((state == CHANGE) && chg_ack);
    assign sub_amt = (state == VEND) ? (sell_id ? PRICE_B_W : PRICE_A_W)
                                     : (chg_coin ? TWO_W : ONE_W);
    // Credit left once the pending subtract lands; drives the next request.
    assign remainder = credit - sub_amt;

    vend_credit_acc #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit_acc (
        .clk      (clk),
        .rstn     (rstn),
        .add_en   (add_en),
        .add_amt  (coin_value(coin)),
        .sub_en   (sub_en),
        .sub_amt  (sub_amt),
        .add_fits (add_fits),
        .credit   (credit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sell      <= 1'b0;
            sell_id   <= 1'b0;
            chg_req   <= 1'b0;
            chg_coin  <= 1'b0;
            coin_rej  <= 1'b0;
            no_credit <= 1'b0;
            busy      <= 1'b0;
        end else begin
            coin_rej  <= 1'b0;
            no_credit <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (cancel) begin
                        coin_rej <= coin_valid;
                        if (credit != '0) begin
                            state    <= CHANGE;
                            chg_req  <= 1'b1;
                            chg_coin <= (credit >= TWO_W);
                            busy     <= 1'b1;
                        end
                    end else if (can_buy) begin
                        state    <= VEND;
                        sell     <= 1'b1;
                        sell_id  <= (sel == SEL_B);
                        busy     <= 1'b1;
                        coin_rej <= coin_valid;
                    end else begin
                        no_credit <= sel_valid;
                        coin_rej  <= coin_valid && !add_fits;
                        state     <= ((credit != '0) || (coin_valid && add_fits)) ? ACCUM : IDLE;
                    end
                end
                VEND: begin
                    coin_rej <= coin_valid;
                    if (vend_ack) begin
                        sell    <= 1'b0;
                        sell_id <= 1'b0;
                        if (remainder != '0) begin
                            state    <= CHANGE;
                            chg_req  <= 1'b1;
                            chg_coin <= (remainder >= TWO_W);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_rej <= coin_valid;
                    if (chg_ack) begin
                        if (remainder == '0) begin
                            state    <= IDLE;
                            chg_req  <= 1'b0;
                            chg_coin <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            chg_coin <= (remainder >= TWO_W);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_ctrl.sv
// tb/tb_vending_ctrl.sv - directed self-checking bench for vending_ctrl
module tb_vending_ctrl;

    localparam int PA   = 3;
    localparam int PB   = 4;
    localparam int W    = 4;
    localparam int MAXC = 10;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [1:0]   coin = 2'b00;
    logic [1:0]   sel = 2'b00;
    logic         cancel = 1'b0;
    logic         vend_ack = 1'b0;
    logic         chg_ack = 1'b0;
    logic         sell, sell_id, chg_req, chg_coin, coin_rej, no_credit, busy;
    logic [W-1:0] credit;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    vending_ctrl #(.PRICE_A(PA), .PRICE_B(PB), .CREDIT_W(W), .MAX_CREDIT(MAXC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .coin      (coin),
        .sel       (sel),
        .cancel    (cancel),
        .vend_ack  (vend_ack),
        .chg_ack   (chg_ack),
        .sell      (sell),
        .sell_id   (sell_id),
        .chg_req   (chg_req),
        .chg_coin  (chg_coin),
        .coin_rej  (coin_rej),
        .no_credit (no_credit),
        .credit    (credit),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: money held, what the machine is doing, pulses owed.
    int m_credit;
    bit m_vending, m_paying, m_item, m_rej, m_noc;

    function automatic int price_of(input bit item);
        return item ? PB : PA;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_credit = 0; m_vending = 0; m_paying = 0; m_item = 0; m_rej = 0; m_noc = 0;
        end else begin
            int  val;
            bit  coin_in, sel_in;
            val     = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : 0;
            coin_in = (val != 0);
            sel_in  = (sel == 2'b01) || (sel == 2'b10);
            m_rej = 0;
            m_noc = 0;
            if (m_vending) begin
                m_rej = coin_in;
                if (vend_ack) begin
                    m_credit  = m_credit - price_of(m_item);
                    m_vending = 0;
                    m_paying  = (m_credit > 0);
                end
            end else if (m_paying) begin
                m_rej = coin_in;
                if (chg_ack) begin
                    m_credit = m_credit - ((m_credit >= 2) ? 2 : 1);
                    m_paying = (m_credit > 0);
                end
            end else if (cancel) begin
                m_rej    = coin_in;
                m_paying = (m_credit > 0);
            end else if (sel_in && m_credit >= price_of(sel == 2'b10)) begin
                m_vending = 1;
                m_item    = (sel == 2'b10);
                m_rej     = coin_in;
            end else begin
                m_noc = sel_in;
                if (coin_in) begin
                    if (m_credit + val > MAXC) m_rej = 1;
                    else m_credit = m_credit + val;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("sell", sell, m_vending);
            if (m_vending) chk("sell_id", sell_id, m_item);
            chk("chg_req", chg_req, m_paying);
            chk("chg_coin", chg_coin, m_paying && (m_credit >= 2));
            chk("coin_rej", coin_rej, m_rej);
            chk("no_credit", no_credit, m_noc);
            chk("credit", credit, m_credit);
            chk("busy", busy, m_vending || m_paying);
        end
    end

    task automatic drv(input logic [1:0] c, input logic [1:0] s, input logic ca,
                       input logic va, input logic ka);
        @(negedge clk);
        coin = c; sel = s; cancel = ca; vend_ack = va; chg_ack = ka;
    endtask

    task automatic nop();
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sell", sell, 0);
        chk("rst_sell_id", sell_id, 0);
        chk("rst_chg_req", chg_req, 0);
        chk("rst_chg_coin", chg_coin, 0);
        chk("rst_coin_rej", coin_rej, 0);
        chk("rst_no_credit", no_credit, 0);
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        rstn  = 1'b1;
        armed = 1'b1;

        // Three half coins buy A exactly.
        drv(2'b01, 2'b00, 0, 0, 0);
        drv(2'b01, 2'b00, 0, 0, 0);
        nop();
        chk("s1_credit2", credit, 2);
        drv(2'b01, 2'b00, 0, 0, 0);
        drv(2'b00, 2'b01, 0, 0, 0);
        nop();
        chk("s1_sell", sell, 1);
        chk("s1_sell_id", sell_id, 0);
        chk("s1_credit3", credit, 3);
        drv(2'b00, 2'b00, 0, 1, 0);
        nop();
        chk("s1_credit0", credit, 0);
        chk("s1_no_chg", chg_req, 0);
        drv(2'b00, 2'b00, 0, 0, 1);
        drv(2'b00, 2'b00, 0, 1, 0);
        nop();

        // B with 2.5 credit leaves one half coin of change.
        drv(2'b10, 2'b00, 0, 0, 0);
        drv(2'b10, 2'b00, 0, 0, 0);
        drv(2'b01, 2'b00, 0, 0, 0);
        drv(2'b00, 2'b10, 0, 0, 0);
        nop();
        chk("s2_sell_id", sell_id, 1);
        chk("s2_credit5", credit, 5);
        drv(2'b00, 2'b00, 0, 1, 0);
        nop();
        chk("s2_chg_req", chg_req, 1);
        chk("s2_chg_coin", chg_coin, 0);
        chk("s2_credit1", credit, 1);
        drv(2'b00, 2'b00, 0, 0, 1);
        nop();
        chk("s2_done", credit, 0);

        // Insufficient select, then cancel refund of 2.5.
        drv(2'b01, 2'b00, 0, 0, 0);
        drv(2'b00, 2'b10, 0, 0, 0);
        nop();
        chk("s3_no_credit", no_credit, 1);
        chk("s3_credit1", credit, 1);
        drv(2'b10, 2'b00, 0, 0, 0);
        chk("s3_pulse_end", no_credit, 0);
        drv(2'b10, 2'b00, 0, 0, 0);
        drv(2'b00, 2'b00, 1, 0, 0);
        nop();
        chk("s3_chg_coin1", chg_coin, 1);
        chk("s3_credit5", credit, 5);
        drv(2'b00, 2'b00, 0, 0, 1);
        drv(2'b00, 2'b00, 0, 0, 1);
        nop();
        chk("s3_credit1", credit, 1);
        chk("s3_chg_coin0", chg_coin, 0);
        drv(2'b00, 2'b00, 0, 0, 1);
        nop();

        // Ceiling, coins during VEND and CHANGE.
        repeat (5) drv(2'b10, 2'b00, 0, 0, 0);
        drv(2'b10, 2'b00, 0, 0, 0);
        nop();
        chk("s4_rej_full", coin_rej, 1);
        chk("s4_credit10", credit, 10);
        drv(2'b01, 2'b00, 0, 0, 0);
        drv(2'b00, 2'b10, 0, 0, 0);
        drv(2'b10, 2'b00, 0, 0, 0);
        nop();
        chk("s4_rej_vend", coin_rej, 1);
        chk("s4_sell", sell, 1);
        drv(2'b00, 2'b00, 0, 1, 0);
        nop();
        chk("s4_credit6", credit, 6);
        drv(2'b01, 2'b00, 0, 0, 0);
        nop();
        chk("s4_rej_chg", coin_rej, 1);
        repeat (3) drv(2'b00, 2'b00, 0, 0, 1);
        nop();
        chk("s4_done", busy, 0);

        // Select and coin in the same cycle: buy wins, coin returned.
        drv(2'b10, 2'b00, 0, 0, 0);
        drv(2'b10, 2'b00, 0, 0, 0);
        drv(2'b10, 2'b01, 0, 0, 0);
        nop();
        chk("s5_sell_id", sell_id, 0);
        chk("s5_rej", coin_rej, 1);
        chk("s5_credit4", credit, 4);
        nop();
        drv(2'b00, 2'b00, 0, 1, 0);
        nop();
        chk("s5_credit1", credit, 1);
        chk("s5_chg_req", chg_req, 1);
        drv(2'b00, 2'b00, 0, 0, 1);
        nop();

        // Invalid select code and invalid coin are ignored.
        drv(2'b01, 2'b00, 0, 0, 0);
        drv(2'b11, 2'b11, 0, 0, 0);
        nop();
        chk("s6_credit1", credit, 1);
        chk("s6_no_credit", no_credit, 0);
        drv(2'b00, 2'b00, 1, 0, 0);
        drv(2'b00, 2'b00, 0, 0, 1);
        nop();

        // Reset while paying change.
        drv(2'b10, 2'b00, 0, 0, 0);
        drv(2'b01, 2'b00, 0, 0, 0);
        drv(2'b00, 2'b00, 1, 0, 0);
        nop();
        chk("s7_chg_req", chg_req, 1);
        chk("s7_credit3", credit, 3);
        #2 rstn = 1'b0;
        #1;
        chk("s7_rst_chg_req", chg_req, 0);
        chk("s7_rst_chg_coin", chg_coin, 0);
        chk("s7_rst_credit", credit, 0);
        chk("s7_rst_busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        nop();
        chk("s7_idle", busy, 0);
        drv(2'b01, 2'b00, 0, 0, 0);
        nop();
        chk("s7_credit1", credit, 1);
        nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
Transaction controller for the coin-operated vending path. It accumulates coin credit in 0.5-unit steps and arbitrates between two products with parameterised prices. It sequences the dispense handshake, then pays back any remainder through a change-dispenser handshake. It sits between the coin slot/keypad front end and the product and change dispensers.

Parameters:
PRICE_A, 3, price of product A in half-units (3 = 1.5)
PRICE_B, 4, price of product B in half-units (4 = 2.0)
CREDIT_W, 4, width of credit register
MAX_CREDIT, 10, credit ceiling in half-units; must be < 2**CREDIT_W

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
coin  input  2  per-cycle coin code: 00 none, 01 = 0.5, 10 = 1.0, 11 invalid (ignored, no reject)
sel  input  2  one-cycle product select: 01 = A, 10 = B, 00/11 ignored
cancel  input  1  one-cycle refund request
vend_ack  input  1  product dispenser acknowledge
chg_ack  input  1  change dispenser acknowledge
sell  output  1  dispense request, held until vend_ack
sell_id  output  1  product being dispensed: 0 = A, 1 = B; valid while sell
chg_req  output  1  change request, held while change is owed
chg_coin  output  1  change coin size while chg_req: 1 = 1.0, 0 = 0.5
coin_rej  output  1  one-cycle pulse: coin returned to user
no_credit  output  1  one-cycle pulse: select made with insufficient credit
credit  output  CREDIT_W  current credit in half-units
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset (async assert, sync release): state IDLE; credit 0; all outputs 0. All outputs are registered.
- States: IDLE (credit==0), ACCUM (credit>0), VEND, CHANGE.
- IDLE/ACCUM priority per cycle, highest first:
  - 1. cancel. If credit>0, go to CHANGE; otherwise no action. Any coin in the same cycle is rejected.
  - 2. Valid sel with pre-coin credit >= price. Go to VEND, set sell=1 and sell_id from the next cycle. A coin in the same cycle is rejected.
  - 3. Valid sel with credit < price. Pulse no_credit next cycle. A coin in the same cycle is still processed.
  - 4. Coin 01/10: credit += 1 or 2. If the result would exceed MAX_CREDIT, credit is unchanged and coin_rej pulses. The state follows credit (IDLE or ACCUM).
- VEND:
  - sell held high; coin, sel and cancel ignored, except that any coin 01/10 pulses coin_rej.
  - When vend_ack is sampled high, credit -= price and sell drops on that same edge.
  - Next state is CHANGE if the remainder is >0, otherwise IDLE.
- CHANGE:
  - chg_req=1 and chg_coin=(credit>=2); coins rejected; sel and cancel ignored.
  - On each cycle with chg_ack: credit -= 2 if chg_coin else 1, and chg_coin is recomputed.
  - When credit reaches 0, chg_req drops on that edge and state becomes IDLE.
  - chg_ack or vend_ack outside its state is ignored.
- Latency: sel-to-sell is 1 cycle; vend_ack-to-chg_req is 1 cycle. Change for N half-units takes floor(N/2)+(N mod 2) acks.
- Width rules: credit arithmetic is unsigned CREDIT_W. MAX_CREDIT bounds the add so it cannot wrap; PRICE <= credit is guaranteed before the subtract.
- Reset mid-VEND or mid-CHANGE drops all requests immediately and discards credit.

Decomposition:
- Shared package vending_pkg holds:
  - state encoding localparams (IDLE=2'd0, ACCUM=2'd1, VEND=2'd2, CHANGE=2'd3)
  - coin codes COIN_NONE/COIN_HALF/COIN_ONE
  - sel codes SEL_A/SEL_B
- One natural sub-module, vend_credit_acc: the credit register with add, saturate-reject and subtract, driven by decoded commands from the FSM.

Test Plan:
- PRICE_A=3: coins 01,01,01 then sel=01 → credit 1,2,3; sell=1 sell_id=0 next cycle; vend_ack → credit 0, IDLE, chg_req never asserts.
- Coins 10,10,01 (credit 5), sel=10 (B=4), vend_ack → credit 1; chg_req=1 chg_coin=0; one chg_ack → credit 0, IDLE.
- Coin 01, sel=10 → no_credit pulse, credit stays 1. Coins 10,10 (credit 5), cancel → CHANGE; chg_coin=1 for 2 acks (credit 3, 1), then chg_coin=0 for 1 ack.
- Coins to credit 10; further coin 10 → coin_rej pulse, credit stays 10. Coin during VEND and during CHANGE → coin_rej each time.
- Credit 4, same cycle sel=01 and coin=10 → VEND with sell_id=0, coin_rej pulse, credit 4 until vend_ack, then 1.
- Deassert rstn while chg_req=1 with credit 3 → all outputs 0 and credit 0 immediately; after release, state is IDLE.
